seg7_scan2: RTL and testbench
=============================

# seg7_scan2

Two-digit multiplexed 7-segment display driver for the two-digit decimal counter output. It consumes the tens and ones BCD digits plus the 99→00 carry flag, and time-multiplexes them onto one shared segment bus with one-hot digit enables. It also stretches the carry flag into a visible decimal-point indication. It sits directly downstream of the BCD counter and drives board-level LED pins.

## Interface
- SCAN_DIV, 1000: CLK cycles per digit slot; legal range ≥ 2.
- CARRY_HOLD, 50: number of frames the decimal point stays lit after a carry; legal range ≥ 1.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- DIN2  in  4  tens digit, BCD, from the counter.
- DIN1  in  4  ones digit, BCD, from the counter.
- CIN  in  1  carry flag from the counter; level, may be high for many cycles.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- DP  out  1  decimal point, active-high, registered.
- DIG  out  2  digit enables, one-hot, active-high, registered: 2'b01 selects ones, 2'b10 selects tens.

## Operation
- Prescaler `pcnt` counts 0 to SCAN_DIV-1 and wraps. `tick` = (pcnt == SCAN_DIV-1).
- Slot register `slot`: 0 means ones, 1 means tens. It resets to 1 and toggles on every `tick`.
- Frame start is a `tick` where `slot` goes from 1 to 0. At frame start, DIN2 and DIN1 are loaded into shadow registers.
  - The displayed pair is always coherent: DIN changes mid-frame are ignored until the next frame start.
- Decode: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F. Any non-BCD value 10–15 decodes to 40 (dash).
- Carry detect:
  - `cin_d` is a registered copy of CIN. A rise is CIN & !cin_d.
  - A rise loads hold counter `hcnt` with CARRY_HOLD.
  - At each frame start, a nonzero `hcnt` decrements by 1.
  - If a rise and a frame start occur in the same cycle, the load wins.
  - A rise while `hcnt` is nonzero reloads it (retrigger).
- DP = 1 only while the ones slot is displayed and `hcnt` ≠ 0. DP is always 0 in the tens slot.
- A CIN level held high produces exactly one rise, so exactly one hold window.
- State after reset:
  - `pcnt`=0, `slot`=1, shadows=0, `cin_d`=0, `hcnt`=0.
  - SEG=7'h00, DIG=2'b00, DP=0.
  - Outputs stay blank until the first `tick`.

## Timing
- SEG, DIG and DP update on the same edge as `tick`. On that edge they take the values for the new slot.
  - At frame start, that edge also loads the shadows, so the ones slot shows the DIN1 value sampled on that edge.
- First display: DIG=01 appears SCAN_DIV cycles after the cycle in which RST is deasserted.
- After that, DIG alternates every SCAN_DIV cycles. A full frame is 2·SCAN_DIV cycles.
- Between ticks, DIG never reads 2'b11, and reads 2'b00 only before the first tick.
- Carry latency:
  - CIN rising at edge k loads `hcnt` at edge k+1.
  - DP asserts at the next ones-slot tick, or immediately if the ones slot is already active.
- DP stays asserted during ones slots for CARRY_HOLD frames.
- RST mid-frame returns every register to its reset value on the next edge, regardless of `tick` or carry state.

## Configuration
- SEG7_LZB_EN defined:
  - Leading-zero blanking. When the tens shadow is 0, the tens slot drives SEG=7'h00 and DIG is still 2'b10.
  - A dash (tens shadow 10–15) is never blanked.
- SEG7_LZB_EN undefined:
  - The tens digit always decodes normally, so 0 shows 3F.

## Structure
- Package `seg7_pkg` holds:
  - Segment constants SEG_0 … SEG_9, SEG_DASH and SEG_BLANK.
  - Digit-enable constants DIG_ONES and DIG_TENS.
- Sub-module `bcd2seg7` is purely combinational: 4-bit in, 7-bit out, using the package constants.
  - Instantiate it once, fed from a slot mux of the shadow registers.
- Prescaler, slot, shadow, carry-hold and output registers all live in `seg7_scan2`.

## Test plan
All scenarios use SCAN_DIV=4, CARRY_HOLD=2.
- Reset, then DIN2=3, DIN1=7 held:
  - DIG=00 and SEG=00 for 3 cycles.
  - Then DIG=01 with SEG=07 for 4 cycles, and DIG=10 with SEG=4F for 4 cycles, repeating.
- DIN1 changes 7→8 during the tens slot:
  - The tens slot is unaffected.
  - The next ones slot shows 7F.
- CIN pulses high for 1 cycle during the tens slot:
  - DP=1 in exactly the next 2 ones slots, 0 otherwise.
  - CIN held high for 20 cycles gives the same result.
- A second CIN rise during the first hold window:
  - The window is extended to 2 frames counted from the second rise.
- DIN2=0, DIN1=5:
  - With SEG7_LZB_EN: tens slot shows DIG=10, SEG=00.
  - Without SEG7_LZB_EN: SEG=3F.
- DIN1=4'hC:
  - The ones slot shows SEG=40.
- RST asserted mid-tens-slot for 1 cycle:
  - The next cycle shows DIG=00, SEG=00, DP=0.
  - Normal scan restarts 3 cycles after RST deasserts.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the two-digit 7-segment scan driver.
//   Segment patterns are {g,f,e,d,c,b,a}, active-high.
//   Digit enables are one-hot, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_NONE  = 2'b00;
    localparam logic [1:0] DIG_ONES  = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

endpackage

// File: rtl/bcd2seg7.sv
// bcd2seg7: combinational BCD to 7-segment decoder.
//   BCD  in  4  digit value; 10-15 are not BCD and show a dash
//   SEG  out 7  segment pattern {g,f,e,d,c,b,a}, active-high
module bcd2seg7
    import seg7_pkg::*;
(
    input  logic [3:0] BCD,
    output logic [6:0] SEG
);

    always_comb begin
        // NOTE: every path assigns SEG (default arm), so no latch is inferred.
        unique case (BCD)
            4'd0:    SEG = SEG_0;
            4'd1:    SEG = SEG_1;
            4'd2:    SEG = SEG_2;
            4'd3:    SEG = SEG_3;
            4'd4:    SEG = SEG_4;
            4'd5:    SEG = SEG_5;
            4'd6:    SEG = SEG_6;
            4'd7:    SEG = SEG_7;
            4'd8:    SEG = SEG_8;
            4'd9:    SEG = SEG_9;
            default: SEG = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan2.sv
// seg7_scan2: two-digit multiplexed 7-segment driver with carry indication.
//   CLK   in  1  system clock, rising edge
//   RST   in  1  synchronous active-high reset
//   DIN2  in  4  tens digit (BCD)
//   DIN1  in  4  ones digit (BCD)
//   CIN   in  1  carry level from the counter; each rise starts a DP window
//   SEG   out 7  shared segment bus {g,f,e,d,c,b,a}, registered
//   DP    out 1  decimal point, lit in the ones slot during a carry window
//   DIG   out 2  one-hot digit enable: 01 ones, 10 tens, 00 before first tick
// Build option: define SEG7_LZB_EN to blank a leading zero in the tens slot.
module seg7_scan2
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int CARRY_HOLD = 50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DIN2,
    input  logic [3:0] DIN1,
    input  logic       CIN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [1:0] DIG
);

    localparam int              PW    = $clog2(SCAN_DIV);
    localparam int              HW    = $clog2(CARRY_HOLD + 1);
    localparam logic [PW-1:0]   PMAX  = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0]   HLOAD = HW'(CARRY_HOLD);

    logic [PW-1:0] pcnt;
    logic          slot;        // 0: ones displayed, 1: tens displayed
    logic [3:0]    sh2, sh1;    // frame-coherent copies of the digits
    logic          cin_d;
    logic [HW-1:0] hcnt;

    logic          tick, frame_start, rise;
    logic [3:0]    sh2_nx, sh1_nx, nib;
    logic [6:0]    seg_dec, seg_nx;
    logic [1:0]    dig_nx;
    logic          dp_nx;

    always_comb begin
        tick        = (pcnt == PMAX);
        frame_start = tick & slot;
        rise        = CIN & ~cin_d;

        // Shadow values as they will be after this edge, so the ones slot
        // entered at frame start shows the freshly sampled DIN1.
        sh2_nx = frame_start ? DIN2 : sh2;
        sh1_nx = frame_start ? DIN1 : sh1;

        // slot is the current slot; the value decoded is for the next one.
        nib    = slot ? sh1_nx : sh2_nx;
        seg_nx = seg_dec;
`ifdef SEG7_LZB_EN
        if (!slot && sh2_nx == 4'd0)
            seg_nx = SEG_BLANK;
`endif
        dig_nx = slot ? DIG_ONES : DIG_TENS;
        // Entering ones: sample the hold count before this frame's decrement,
        // so a window of CARRY_HOLD covers CARRY_HOLD full ones slots.
        dp_nx  = slot ? ((hcnt != '0) | rise) : 1'b0;
    end

    bcd2seg7 u_dec (
        .BCD (nib),
        .SEG (seg_dec)
    );

    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so all registers see
        // pre-edge values regardless of statement order.
        if (RST) begin
            pcnt  <= '0;
            slot  <= 1'b1;
            sh2   <= 4'd0;
            sh1   <= 4'd0;
            cin_d <= 1'b0;
            hcnt  <= '0;
            SEG   <= SEG_BLANK;
            DIG   <= DIG_NONE;
            DP    <= 1'b0;
        end else begin
            pcnt  <= tick ? '0 : pcnt + 1'b1;
            cin_d <= CIN;
            sh2   <= sh2_nx;
            sh1   <= sh1_nx;

            // A rise beats the frame-start decrement and retriggers the window.
            if (rise)
                hcnt <= HLOAD;
            else if (frame_start && hcnt != '0)
                hcnt <= hcnt - 1'b1;

            if (tick) begin
                slot <= ~slot;
                SEG  <= seg_nx;
                DIG  <= dig_nx;
                DP   <= dp_nx;
            end else if (!slot) begin
                // A carry during an active ones slot lights DP right away.
                DP   <= DP | rise;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan2.sv
// tb_seg7_scan2: directed self-checking bench for seg7_scan2
// (SCAN_DIV=4, CARRY_HOLD=2). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point.
module tb_seg7_scan2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] DIN2 = 4'd3;
    logic [3:0] DIN1 = 4'd7;
    logic       CIN = 1'b0;
    logic [6:0] SEG;
    logic       DP;
    logic [1:0] DIG;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    seg7_scan2 #(.SCAN_DIV(4), .CARRY_HOLD(2)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .DIN2 (DIN2),
        .DIN1 (DIN1),
        .CIN  (CIN),
        .SEG  (SEG),
        .DP   (DP),
        .DIG  (DIG)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] dig_e,
                         input logic [6:0] seg_e, input logic dp_e);
        n_tests++;
        assert (DIG === dig_e && SEG === seg_e && DP === dp_e)
        else begin
            n_fail++;
            $error("FAIL %s: got DIG=%b SEG=%h DP=%b, want DIG=%b SEG=%h DP=%b",
                   tag, DIG, SEG, DP, dig_e, seg_e, dp_e);
        end
    endtask

    // n consecutive cycles that must all show the same outputs
    task automatic span(input string tag, input logic [1:0] dig_e,
                        input logic [6:0] seg_e, input logic dp_e, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            check($sformatf("%s[%0d]", tag, i), dig_e, seg_e, dp_e);
        end
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        check("reset", 2'b00, 7'h00, 1'b0);
        RST = 1'b0;

        // Blank until first tick, then alternate ones/tens
        span("pre",    2'b00, 7'h00, 1'b0, 3);
        span("ones7a", 2'b01, 7'h07, 1'b0, 4);
        span("tens3a", 2'b10, 7'h4F, 1'b0, 4);
        span("ones7b", 2'b01, 7'h07, 1'b0, 4);

        // DIN1 change mid-tens: tens unaffected, next ones shows 8
        span("tens3b", 2'b10, 7'h4F, 1'b0, 1);
        DIN1 = 4'd8;
        span("tens3c", 2'b10, 7'h4F, 1'b0, 3);
        span("ones8a", 2'b01, 7'h7F, 1'b0, 1);
        // DIN1 change mid-ones: frame stays coherent
        DIN1 = 4'd9;
        span("ones8b", 2'b01, 7'h7F, 1'b0, 3);
        span("tens3d", 2'b10, 7'h4F, 1'b0, 4);
        span("ones9a", 2'b01, 7'h6F, 1'b0, 4);

        // One-cycle CIN pulse in tens slot: DP in the next two ones slots
        span("p_t0",   2'b10, 7'h4F, 1'b0, 1);
        CIN = 1'b1;
        span("p_t1",   2'b10, 7'h4F, 1'b0, 1);
        CIN = 1'b0;
        span("p_t2",   2'b10, 7'h4F, 1'b0, 2);
        span("p_o1",   2'b01, 7'h6F, 1'b1, 4);
        span("p_t3",   2'b10, 7'h4F, 1'b0, 4);
        span("p_o2",   2'b01, 7'h6F, 1'b1, 4);
        span("p_t4",   2'b10, 7'h4F, 1'b0, 4);
        span("p_o3",   2'b01, 7'h6F, 1'b0, 4);

        // CIN held for 20 cycles: still a single two-frame window
        span("h_t0",   2'b10, 7'h4F, 1'b0, 1);
        CIN = 1'b1;
        span("h_t1",   2'b10, 7'h4F, 1'b0, 3);
        span("h_o1",   2'b01, 7'h6F, 1'b1, 4);
        span("h_t2",   2'b10, 7'h4F, 1'b0, 4);
        span("h_o2",   2'b01, 7'h6F, 1'b1, 4);
        span("h_t3",   2'b10, 7'h4F, 1'b0, 4);
        span("h_o3a",  2'b01, 7'h6F, 1'b0, 1);
        CIN = 1'b0;
        span("h_o3b",  2'b01, 7'h6F, 1'b0, 3);

        // Retrigger inside the window: two frames counted from second rise
        span("r_t0",   2'b10, 7'h4F, 1'b0, 1);
        CIN = 1'b1;
        span("r_t1",   2'b10, 7'h4F, 1'b0, 1);
        CIN = 1'b0;
        span("r_t2",   2'b10, 7'h4F, 1'b0, 2);
        span("r_o1",   2'b01, 7'h6F, 1'b1, 4);
        span("r_t3",   2'b10, 7'h4F, 1'b0, 1);
        CIN = 1'b1;
        span("r_t4",   2'b10, 7'h4F, 1'b0, 1);
        CIN = 1'b0;
        span("r_t5",   2'b10, 7'h4F, 1'b0, 2);
        span("r_o2",   2'b01, 7'h6F, 1'b1, 4);
        span("r_t6",   2'b10, 7'h4F, 1'b0, 4);
        span("r_o3",   2'b01, 7'h6F, 1'b1, 4);
        span("r_t7",   2'b10, 7'h4F, 1'b0, 4);
        span("r_o4",   2'b01, 7'h6F, 1'b0, 4);

        // Tens zero: blanked only with leading-zero blanking
        DIN2 = 4'd0;
        DIN1 = 4'd5;
        span("z_t0",   2'b10, 7'h4F, 1'b0, 4);
        span("z_o1",   2'b01, 7'h6D, 1'b0, 4);
        span("z_t1",   2'b10, TENS_ZERO, 1'b0, 4);

        // Non-BCD digits show a dash, never blanked
        DIN2 = 4'hA;
        DIN1 = 4'hC;
        span("d_o1",   2'b01, 7'h40, 1'b0, 4);
        span("d_t1",   2'b10, 7'h40, 1'b0, 4);
        span("d_o2",   2'b01, 7'h40, 1'b0, 4);

        // Reset mid-tens with a carry pending: everything clears
        span("x_t0",   2'b10, 7'h40, 1'b0, 1);
        CIN = 1'b1;
        span("x_t1",   2'b10, 7'h40, 1'b0, 1);
        CIN = 1'b0;
        RST = 1'b1;
        cyc();
        check("x_rst", 2'b00, 7'h00, 1'b0);
        RST = 1'b0;
        span("x_pre",  2'b00, 7'h00, 1'b0, 3);
        span("x_o1",   2'b01, 7'h40, 1'b0, 4);
        span("x_t2",   2'b10, 7'h40, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
